// File: rtl/score_tracker_if.sv
// Bundles the score_tracker round-control inputs, per-player hit/miss pulses and
// the scoreboard outputs; master = game logic side, slave = score_tracker.
interface score_tracker_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 8,
    parameter int LEAD_W      = 1
);
    // Handshake: no ready path. hit[i]/miss[i] are single-cycle valid qualifiers
    // sampled on every clock; the tracker always accepts, so the sender never stalls.
    logic                           game_active;
    logic                           timer_expired;
    logic [NUM_PLAYERS-1:0]         hit;
    logic [NUM_PLAYERS-1:0]         miss;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores;
    logic [1:0]                     state;
    logic [LEAD_W-1:0]              leader;
    logic                           tie;
    logic [SCORE_W-1:0]             high_score;
    logic                           new_high;

    modport master (
        output game_active, timer_expired, hit, miss,
        input  scores, state, leader, tie, high_score, new_high
    );

    modport slave (
        input  game_active, timer_expired, hit, miss,
        output scores, state, leader, tie, high_score, new_high
    );
endinterface

// File: rtl/score_tracker.sv
// Multi-player saturating score engine with round FSM, leader/tie compare and session high score.
// Define SCORE_COMBO_EN to enable the per-player hit-streak combo bonus.
module score_tracker #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 8,
    parameter int MAX_SCORE   = 200,
    parameter int PENALTY     = 1,
    parameter int COMBO_LEN   = 4
) (
    input  logic            clkIn,
    input  logic            reset,
    score_tracker_if.slave  bus
);
    localparam int LEAD_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W+1)'(MAX_SCORE);
    localparam logic [SCORE_W:0] PEN_EXT = (SCORE_W+1)'(PENALTY);

    if (COMBO_LEN < 2 || MAX_SCORE >= (1 << SCORE_W)) begin : g_bad_params
        $error("score_tracker: COMBO_LEN must be >= 2 and MAX_SCORE < 2**SCORE_W");
    end

    logic [1:0]                            state_q, state_d;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   score_q, score_d;
    logic [LEAD_W-1:0]                     leader_q, leader_d;
    logic                                  tie_q, tie_d;
    logic [SCORE_W-1:0]                    high_q, high_d;
    logic                                  new_high_q, new_high_d;
    logic [SCORE_W-1:0]                    max_v;
    logic [2:0]                            top_cnt;

`ifdef SCORE_COMBO_EN
    localparam int STREAK_W = $clog2(COMBO_LEN);
    logic [NUM_PLAYERS-1:0][STREAK_W-1:0] streak_q, streak_d;
`endif

    // Sums are formed one bit wider than the score so the ceiling test sees any carry.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s, input logic [1:0] inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W+1)'(inc);
        return (sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] s);
        logic [SCORE_W:0] diff;
        diff = {1'b0, s} - PEN_EXT;
        return ({1'b0, s} < PEN_EXT) ? '0 : diff[SCORE_W-1:0];
    endfunction

    // Lowest index wins ties because only a strictly greater score displaces the leader.
    always_comb begin
        max_v    = score_q[0];
        leader_d = '0;
        top_cnt  = '0;
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (score_q[i] > max_v) begin
                max_v    = score_q[i];
                leader_d = LEAD_W'(i);
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (score_q[i] == max_v) top_cnt = top_cnt + 3'd1;
        end
        tie_d = (top_cnt > 3'd1);
    end

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = 1'b0;
`ifdef SCORE_COMBO_EN
        streak_d   = streak_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.game_active) begin
                    state_d = ST_PLAY;
                    score_d = '0;
`ifdef SCORE_COMBO_EN
                    streak_d = '0;
`endif
                end
            end
            ST_PLAY: begin
                if (bus.timer_expired) begin
                    state_d = ST_FROZEN;
                    if (max_v > high_q) begin
                        high_d     = max_v;
                        new_high_d = 1'b1;
                    end
                end else if (!bus.game_active) begin
                    state_d = ST_IDLE;
                end else begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (bus.hit[i]) begin
`ifdef SCORE_COMBO_EN
                            if (streak_q[i] == STREAK_W'(COMBO_LEN - 1)) begin
                                score_d[i]  = sat_add(score_q[i], 2'd2);
                                streak_d[i] = '0;
                            end else begin
                                score_d[i]  = sat_add(score_q[i], 2'd1);
                                streak_d[i] = streak_q[i] + STREAK_W'(1);
                            end
`else
                            score_d[i] = sat_add(score_q[i], 2'd1);
`endif
                        end else if (bus.miss[i]) begin
                            score_d[i] = sat_sub(score_q[i]);
`ifdef SCORE_COMBO_EN
                            streak_d[i] = '0;
`endif
                        end
                    end
                end
            end
            ST_FROZEN: begin
                if (!bus.game_active) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            leader_q   <= '0;
            tie_q      <= 1'b0;
            high_q     <= '0;
            new_high_q <= 1'b0;
`ifdef SCORE_COMBO_EN
            streak_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            leader_q   <= leader_d;
            tie_q      <= tie_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
`ifdef SCORE_COMBO_EN
            streak_q   <= streak_d;
`endif
        end
    end

    assign bus.scores     = score_q;
    assign bus.state      = state_q;
    assign bus.leader     = leader_q;
    assign bus.tie        = tie_q;
    assign bus.high_score = high_q;
    assign bus.new_high   = new_high_q;
endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: vector table, directed corner sequences and random rounds
// checked every cycle against a rule-level reference model.
module tb_score_tracker;
    localparam int NP   = 2;
    localparam int SW   = 8;
    localparam int LW   = 1;
    localparam int MAXS = 200;
    localparam int PEN  = 1;
    localparam int CL   = 4;

`ifdef SCORE_COMBO_EN
    localparam bit COMBO = 1'b1;
`else
    localparam bit COMBO = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_tracker_if #(.NUM_PLAYERS(NP), .SCORE_W(SW), .LEAD_W(LW)) ifc ();

    score_tracker #(
        .NUM_PLAYERS(NP), .SCORE_W(SW), .MAX_SCORE(MAXS), .PENALTY(PEN), .COMBO_LEN(CL)
    ) dut (
        .clkIn (clk),
        .reset (rst_n),
        .bus   (ifc.slave)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [SW-1:0] exp_q[$];

    int m_score[NP];
    int m_streak[NP];
    int m_state, m_leader, m_tie, m_high, m_new_high;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_score(input int i);
        return int'(ifc.scores[i*SW +: SW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_score[i]  = 0;
            m_streak[i] = 0;
        end
        m_state = 0; m_leader = 0; m_tie = 0; m_high = 0; m_new_high = 0;
        exp_q.delete();
    endtask

    // Reference: leader/tie describe the scores as they stood before this edge.
    task automatic model_step(input logic ga, input logic te, input logic [NP-1:0] h, input logic [NP-1:0] m);
        int prev[NP];
        int mx, cnt, gain;
        prev = m_score;
        mx = prev[0];
        m_leader = 0;
        for (int i = 1; i < NP; i++) if (prev[i] > mx) begin mx = prev[i]; m_leader = i; end
        cnt = 0;
        for (int i = 0; i < NP; i++) if (prev[i] == mx) cnt++;
        m_tie = (cnt > 1) ? 1 : 0;
        m_new_high = 0;
        case (m_state)
            0: if (ga) begin
                m_state = 1;
                for (int i = 0; i < NP; i++) begin m_score[i] = 0; m_streak[i] = 0; end
            end
            1: if (te) begin
                m_state = 2;
                if (mx > m_high) begin
                    m_high = mx;
                    m_new_high = 1;
                    exp_q.push_back(SW'(mx));
                end
            end else if (!ga) begin
                m_state = 0;
            end else begin
                for (int i = 0; i < NP; i++) begin
                    if (h[i]) begin
                        gain = (COMBO && m_streak[i] == CL - 1) ? 2 : 1;
                        m_streak[i] = (gain == 2) ? 0 : m_streak[i] + 1;
                        m_score[i] = (m_score[i] + gain > MAXS) ? MAXS : m_score[i] + gain;
                    end else if (m[i]) begin
                        m_streak[i] = 0;
                        m_score[i] = (m_score[i] < PEN) ? 0 : m_score[i] - PEN;
                    end
                end
            end
            default: if (!ga) m_state = 0;
        endcase
    endtask

    task automatic check_all();
        for (int i = 0; i < NP; i++) chk($sformatf("model_score%0d", i), dut_score(i), m_score[i]);
        chk("model_state", int'(ifc.state), m_state);
        chk("model_leader", int'(ifc.leader), m_leader);
        chk("model_tie", int'(ifc.tie), m_tie);
        chk("model_high", int'(ifc.high_score), m_high);
        chk("model_new_high", int'(ifc.new_high), m_new_high);
        if (ifc.new_high) begin
            if (exp_q.size() == 0) chk("high_queue_empty", int'(ifc.high_score), -1);
            else chk("high_queue", int'(ifc.high_score), int'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic ga, input logic te, input logic [NP-1:0] h, input logic [NP-1:0] m);
        ifc.game_active   = ga;
        ifc.timer_expired = te;
        ifc.hit           = h;
        ifc.miss          = m;
        @(posedge clk);
        model_step(ga, te, h, m);
        #1;
        check_all();
    endtask

    task automatic hits(input int n, input logic [NP-1:0] h);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, h, '0);
    endtask

    typedef struct {
        logic ga; logic te; logic [NP-1:0] h; logic [NP-1:0] m;
        int s0; int s1; int st; int ld; int tie;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int n0, n1;
        ifc.game_active = 1'b0; ifc.timer_expired = 1'b0; ifc.hit = '0; ifc.miss = '0;
        model_reset();

        // reset values
        #12;
        check_all();
        chk("rst_scores", int'(ifc.scores), 0);
        chk("rst_tie", int'(ifc.tie), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ga te  h      m      s0 s1 st ld tie
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 1, 0, 1};
        tbl[1]  = '{1'b1, 1'b0, 2'b01, 2'b00, 1, 0, 1, 0, 1};
        tbl[2]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2, 0, 1, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 2'b01, 2'b00, 3, 0, 1, 0, 0};
        tbl[4]  = '{1'b1, 1'b0, 2'b00, 2'b00, 3, 0, 1, 0, 0};
        tbl[5]  = '{1'b1, 1'b0, 2'b10, 2'b00, 3, 1, 1, 0, 0};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 2'b01, 2, 1, 1, 0, 0};
        tbl[7]  = '{1'b1, 1'b0, 2'b10, 2'b10, 2, 2, 1, 0, 0};
        tbl[8]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2, 2, 1, 0, 1};
        tbl[9]  = '{1'b1, 1'b0, 2'b10, 2'b00, 2, 3, 1, 0, 1};
        tbl[10] = '{1'b1, 1'b0, 2'b00, 2'b00, 2, 3, 1, 1, 0};
        tbl[11] = '{1'b1, 1'b1, 2'b01, 2'b00, 2, 3, 2, 1, 0};
        for (int v = 0; v < 12; v++) begin
            drive(tbl[v].ga, tbl[v].te, tbl[v].h, tbl[v].m);
            chk($sformatf("vec%0d_s0", v), dut_score(0), tbl[v].s0);
            chk($sformatf("vec%0d_s1", v), dut_score(1), tbl[v].s1);
            chk($sformatf("vec%0d_state", v), int'(ifc.state), tbl[v].st);
            chk($sformatf("vec%0d_leader", v), int'(ifc.leader), tbl[v].ld);
            chk($sformatf("vec%0d_tie", v), int'(ifc.tie), tbl[v].tie);
        end
        chk("vec_high", int'(ifc.high_score), 3);
        chk("vec_new_high", int'(ifc.new_high), 1);
        drive(1'b0, 1'b0, '0, '0);
        chk("vec_new_high_drop", int'(ifc.new_high), 0);

        // saturation, zero floor, hit+miss, abort
        drive(1'b1, 1'b0, '0, '0);
        hits(250, 2'b10);
        chk("sat_200", dut_score(1), 200);
        drive(1'b1, 1'b0, '0, 2'b10);
        chk("sat_miss_199", dut_score(1), 199);
        drive(1'b1, 1'b0, '0, 2'b01);
        chk("floor_0", dut_score(0), 0);
        drive(1'b1, 1'b0, 2'b01, 2'b01);
        chk("hit_wins_1", dut_score(0), 1);
        drive(1'b0, 1'b0, '0, '0);
        chk("abort_state", int'(ifc.state), 0);
        chk("abort_held", dut_score(1), 199);
        chk("abort_high", int'(ifc.high_score), 3);
        chk("abort_no_pulse", int'(ifc.new_high), 0);
        drive(1'b1, 1'b0, '0, '0);
        chk("restart_clear", dut_score(1), 0);

        // freeze at 7/5 with a discarded hit, then an equal round
        n0 = COMBO ? 6 : 7;
        n1 = COMBO ? 4 : 5;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) drive(1'b1, 1'b0, '0, '0);
            for (int k = 0; k < n0; k++) drive(1'b1, 1'b0, {k < n1, 1'b1}, '0);
            drive(1'b1, 1'b1, 2'b10, '0);
            chk($sformatf("freeze%0d_state", r), int'(ifc.state), 2);
            chk($sformatf("freeze%0d_s0", r), dut_score(0), 7);
            chk($sformatf("freeze%0d_s1", r), dut_score(1), 5);
            chk($sformatf("freeze%0d_high", r), int'(ifc.high_score), 7);
            chk($sformatf("freeze%0d_pulse", r), int'(ifc.new_high), (r == 0) ? 1 : 0);
            drive(1'b1, 1'b0, '0, '0);
            chk($sformatf("freeze%0d_pulse_once", r), int'(ifc.new_high), 0);
            drive(1'b0, 1'b0, '0, '0);
        end

        // combo streaks (plain +1 scoring when the feature is off)
        drive(1'b1, 1'b0, '0, '0);
        hits(4, 2'b01);
        chk("combo_4hits", dut_score(0), COMBO ? 5 : 4);
        hits(3, 2'b10);
        drive(1'b1, 1'b0, '0, 2'b10);
        hits(4, 2'b10);
        chk("combo_break", dut_score(1), COMBO ? 7 : 6);
        drive(1'b0, 1'b0, '0, '0);

        // randomized rounds with one asynchronous reset in the middle
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                #3 rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                chk("async_rst_scores", int'(ifc.scores), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 59) == 0),
                  NP'($urandom_range(0, 3)), NP'($urandom_range(0, 3) & $urandom_range(0, 3)));
        end

        chk("high_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
